// File: rtl/multi_digit_7seg_scanner_if.sv
// ----------------------------------------------------------------------------
// multi_digit_7seg_scanner_if
// Bundles the display-content inputs and the multiplexed LED drive outputs of
// the 7-segment scanner.
//   master : the controller side; drives the content and observes the LED pins.
//   slave  : the scanner itself; consumes the content and drives the LED pins.
// Signals:
//   digits      [4*N-1:0] hex nibbles, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_in       [N-1:0]   decimal point request per digit (1 = lit)
//   blank       [N-1:0]   force digit dark (1 = dark)
//   blink       [N-1:0]   blink enable per digit
//   lz_en                 leading-zero suppression enable
//   brightness  [3:0]     duty level 0..15
//   seg         [6:0]     segments a..g, active low
//   dp                    decimal point, active low
//   an          [N-1:0]   digit anodes, active low
//   frame_start           one-cycle pulse at each frame boundary
// ----------------------------------------------------------------------------
interface multi_digit_7seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic                    lz_en;
  logic [3:0]              brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits, dp_in, blank, blink, lz_en, brightness,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  digits, dp_in, blank, blink, lz_en, brightness,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/multi_digit_7seg_scanner.sv
// ----------------------------------------------------------------------------
// multi_digit_7seg_scanner
// Time-multiplexes NUM_DIGITS hex digits onto a common-anode 7-segment display.
// Each digit owns a slot of SCAN_DIV clocks; a frame is NUM_DIGITS slots.
// Display content is snapshotted at every frame boundary so a frame never
// mixes old and new values. Supports per-digit blank/blink/decimal point,
// leading-zero suppression and 16-level PWM brightness.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : slave side of multi_digit_7seg_scanner_if (content in, LED pins out)
// ----------------------------------------------------------------------------
module multi_digit_7seg_scanner #(
  parameter int NUM_DIGITS   = 4,    // 2..8
  parameter int SCAN_DIV     = 16,   // multiple of 16, >= 16
  parameter int BLINK_FRAMES = 250   // >= 1
) (
  input logic                           clk,
  input logic                           rst,
  multi_digit_7seg_scanner_if.slave     bus
);

  localparam int CW   = $clog2(SCAN_DIV);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int UNIT = SCAN_DIV / 16;   // duty cycles per brightness step

  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lz_en;
    logic [3:0]              brightness;
  } shadow_t;

  logic [CW-1:0]         div_cnt_q,     div_cnt_d;
  logic [IW-1:0]         digit_idx_q,   digit_idx_d;
  logic [FW-1:0]         frame_cnt_q,   frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  frame_start_q, frame_start_d;
  shadow_t               shadow_q,      shadow_d;
  logic [6:0]            seg_q,         seg_d;
  logic                  dp_q,          dp_d;
  logic [NUM_DIGITS-1:0] an_q,          an_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_dark;
  logic [CW:0]           duty;
  logic                  lit;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;   // F
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a value before any conditional logic, so no
    // path through this block can leave one unassigned and infer a latch.
    slot_end      = (div_cnt_q == DIV_LAST);
    frame_end     = slot_end && (digit_idx_q == IDX_LAST);

    div_cnt_d     = slot_end ? '0 : div_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    shadow_d      = shadow_q;
    frame_start_d = frame_end;   // registered: high in the cycle digit_idx is back at 0

    if (slot_end) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end

    if (frame_end) begin
      shadow_d.digits     = bus.digits;
      shadow_d.dp_in      = bus.dp_in;
      shadow_d.blank      = bus.blank;
      shadow_d.blink      = bus.blink;
      shadow_d.lz_en      = bus.lz_en;
      shadow_d.brightness = bus.brightness;
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + 1'b1;
      end
    end

    // Leading-zero suppression: scan from the most significant digit down,
    // a digit is dark while it and everything above it is zero. Digit 0 is
    // always shown so an all-zero value still reads "0".
    zero_run = 1'b1;
    lz_dark  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow_q.digits[4*i +: 4] == 4'h0);
      if (i != 0) lz_dark[i] = shadow_q.lz_en & zero_run;
    end

    sel_nib  = '0;
    sel_dp   = 1'b0;
    sel_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == digit_idx_q) begin
        sel_nib  = shadow_q.digits[4*i +: 4];
        sel_dp   = shadow_q.dp_in[i];
        sel_dark = shadow_q.blank[i] | lz_dark[i] | (shadow_q.blink[i] & blink_phase_q);
      end
    end

    // brightness 15 gives duty == SCAN_DIV, i.e. the whole slot.
    duty = (CW+1)'((int'(shadow_q.brightness) + 1) * UNIT);
    lit  = !sel_dark && ({1'b0, div_cnt_q} < duty);

    an_d = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d[digit_idx_q] = 1'b0;
      seg_d             = hex_to_seg(sel_nib);
      dp_d              = ~sel_dp;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      digit_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_start_q <= 1'b0;
      shadow_q      <= '0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_start_q <= frame_start_d;
      shadow_q      <= shadow_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/multi_digit_7seg_scanner.md
MULTI_DIGIT_7SEG_SCANNER -- requirements
Module: multi_digit_7seg_scanner

Interface
Parameters:
REQ-001 NUM_DIGITS, 4, number of multiplexed digits, legal range 2..8.
REQ-002 SCAN_DIV, 16, clk cycles per digit slot; SHALL be a multiple of 16, minimum 16.
REQ-003 BLINK_FRAMES, 250, full scan frames per blink half-period, minimum 1.

Ports:
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i]; digit 0 is rightmost.
REQ-007 dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 blank  in  NUM_DIGITS  force digit dark, 1 = dark.
REQ-009 blink  in  NUM_DIGITS  blink enable per digit.
REQ-010 lz_en  in  1  leading-zero suppression enable.
REQ-011 brightness  in  4  duty level 0..15.
REQ-012 seg  out  7  segments, active low; seg[0]=a ... seg[6]=g.
REQ-013 dp  out  1  decimal point, active low.
REQ-014 an  out  NUM_DIGITS  digit anodes, active low, one-hot-low or all high.
REQ-015 frame_start  out  1  one-cycle pulse at each frame boundary.

Function
REQ-016 Slot counter div_cnt SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit_idx SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 On the cycle digit_idx wraps to 0, digits, dp_in, blank, blink, lz_en and brightness SHALL be captured into shadow registers, and frame_start SHALL pulse high for exactly that cycle; display content SHALL come only from shadow registers (no mid-frame tearing).
REQ-018 Decoder SHALL map 0-9 to standard glyphs and A-F to A,b,C,d,E,F; e.g. 0 -> 7'b1000000, 4 -> 7'b0011001, 8 -> 7'b0000000.
REQ-019 With shadow lz_en=1, digit i (i>0) SHALL be dark when it and all higher digits are 0; digit 0 SHALL never be suppressed.
REQ-020 Frame counter SHALL count completed frames modulo BLINK_FRAMES and toggle blink_phase on wrap; a digit with shadow blink=1 SHALL be dark while blink_phase=1.
REQ-021 Duty SHALL be ((brightness+1)*SCAN_DIV)/16 cycles; the selected anode SHALL be low only while div_cnt < duty; brightness 15 = full slot.
REQ-022 A dark digit (blank, suppressed, blink-off or outside duty) SHALL drive an all high, seg=7'h7F, dp=1.
REQ-023 seg, dp, an SHALL be registered and SHALL change in the same cycle; they reflect counter state with exactly one cycle latency.
REQ-024 At most one an bit SHALL be low in any cycle.

Reset
REQ-025 While rst=1: an all 1, seg=7'h7F, dp=1, frame_start=0, div_cnt=0, digit_idx=0, frame count 0, blink_phase=0, all shadows 0.
REQ-026 Reset asserted mid-slot SHALL take effect immediately without waiting for clk; after release, scanning SHALL restart at digit 0 with shadows 0 until the first frame_start.

Verification (NUM_DIGITS=4, SCAN_DIV=16 unless stated)
REQ-027 Reset: assert rst mid-slot -> an=4'b1111, seg=7'h7F, dp=1 asynchronously; release -> first slot on an[0], frame_start after 64 cycles.
REQ-028 Scan: digits=16'h1234, brightness=15, lz_en=0 -> from next frame an 1110/1101/1011/0111 for 16 cycles each with seg 7'b0011001/0110000/0100100/1111001.
REQ-029 Suppression: digits=16'h0050, lz_en=1 -> slots 3 and 2 all an high; slot 1 seg=7'b0010010; slot 0 seg=7'b1000000; digits=16'h0000 -> only digit 0 shows 0.
REQ-030 Brightness: brightness=0 -> an low 1 cycle per 16-cycle slot; brightness=7 -> 8 cycles; change mid-frame applies only after next frame_start.
REQ-031 Tearing: change digits during slot 2 -> slots 2,3 of current frame keep old values; new values appear from next frame_start.
REQ-032 Blink: BLINK_FRAMES=2, blink=4'b0010 -> digit 1 lit in frames 0,1,4,5, dark in frames 2,3; other digits unaffected; dp_in=4'b0001 -> dp=0 only in slot 0.
